emmc_ddr_dat_tx_sequencer: RTL

//  Sequences eMMC DAT-line block writes in DDR mode over DATA_WIDTH IODDR cells.

---
 rtl/emmc_ddr_pkg.sv | 19 +
 rtl/crc16_serial.sv | 27 ++
 rtl/emmc_ddr_dat_tx_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/emmc_ddr_pkg.sv
// rtl/emmc_ddr_pkg.sv - shared types, error codes and CRC16 step for the eMMC DDR DAT transmit path
package emmc_ddr_pkg;

  typedef enum logic [3:0] {
    IDLE, START, DATA, CRC, END, STAT_WAIT, STAT, BUSY, GAP, DONE
  } state_e;

  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_CRC_STATUS = 2'b01;
  localparam logic [1:0] ERR_UNDERRUN   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// rtl/crc16_serial.sv - one-bit-per-clock CRC16-CCITT engine, init 0, synchronous clear
module crc16_serial
  import emmc_ddr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc16_step(crc_q, din_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/emmc_ddr_dat_tx_sequencer.sv
// rtl/emmc_ddr_dat_tx_sequencer.sv - frames DDR block writes onto the DAT lines and handles CRC status and busy
module emmc_ddr_dat_tx_sequencer
  import emmc_ddr_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int STATUS_WAIT  = 16,
  parameter int BUSY_TIMEOUT = 1048575
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [9:0]              block_words_i,
  input  logic [15:0]             block_count_i,
  input  logic [2*DATA_WIDTH-1:0] tx_data_i,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  output logic [DATA_WIDTH-1:0]   dat_pos_o,
  output logic [DATA_WIDTH-1:0]   dat_neg_o,
  output logic                    dat_oe_o,
  input  logic                    dat0_rx_pos_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              err_code_o
);

  localparam int DW      = DATA_WIDTH;
  localparam int MAX_A   = (BUSY_TIMEOUT > STATUS_WAIT) ? BUSY_TIMEOUT : STATUS_WAIT;
  localparam int MAX_B   = (GAP_CYCLES > 16) ? GAP_CYCLES : 16;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [9:0]      bw_q, bw_d, word_q, word_d;
  logic [15:0]     blk_q, blk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      stat_q, stat_d;
  logic            bad_q, bad_d;
  logic [DW-1:0]   pos_q, pos_d, neg_q, neg_d;
  logic            oe_q, oe_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic            crc_clr, crc_en;
  logic [15:0]     crc_w [2*DW];

  // Engines 0..DW-1 carry the rising-edge bit of each line, DW..2DW-1 the falling-edge bit.
  for (genvar j = 0; j < 2*DW; j++) begin : g_crc
    crc16_serial u_crc (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (crc_clr),
      .en_i    (crc_en),
      .din_i   (tx_data_i[j]),
      .crc_o   (crc_w[j])
    );
  end

  always_comb begin
    state_d = state_q;
    bw_d    = bw_q;
    word_d  = word_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;
    bad_d   = bad_q;
    pos_d   = '1;
    neg_d   = '1;
    oe_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        crc_clr = 1'b1;
        if (start_i) begin
          err_d = ERR_OK;
          bad_d = 1'b0;
          bw_d  = block_words_i;
          blk_d = block_count_i;
          if (block_words_i == 10'd0 || block_count_i == 16'd0) done_d  = 1'b1;
          else                                                  state_d = START;
        end
      end
      START: begin
        oe_d    = 1'b1;
        pos_d   = '0;
        neg_d   = '0;
        word_d  = bw_q;
        state_d = DATA;
      end
      DATA: begin
        if (tx_valid_i) begin
          oe_d   = 1'b1;
          crc_en = 1'b1;
          pos_d  = tx_data_i[DW-1:0];
          neg_d  = tx_data_i[2*DW-1:DW];
          if (word_q == 10'd1) begin
            state_d = CRC;
            cnt_d   = '0;
          end else begin
            word_d = word_q - 10'd1;
          end
        end else begin
          err_d   = ERR_UNDERRUN;
          state_d = DONE;
        end
      end
      CRC: begin
        oe_d = 1'b1;
        for (int i = 0; i < DW; i++) begin
          pos_d[i] = crc_w[i][4'd15 - cnt_q[3:0]];
          neg_d[i] = crc_w[DW+i][4'd15 - cnt_q[3:0]];
        end
        if (cnt_q[3:0] == 4'd15) state_d = END;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      END: begin
        oe_d    = 1'b1;
        blk_d   = blk_q - 16'd1;
        cnt_d   = '0;
        state_d = STAT_WAIT;
      end
      STAT_WAIT: begin
        crc_clr = 1'b1;
        if (!dat0_rx_pos_i) begin
          state_d = STAT;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STATUS_WAIT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STAT: begin
        // Three token bits, then the token end bit is ignored.
        if (cnt_q == CW'(3)) begin
          if (stat_q != 3'b010) bad_d = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
        end else begin
          stat_d = {stat_q[1:0], dat0_rx_pos_i};
          cnt_d  = cnt_q + CW'(1);
        end
      end
      BUSY: begin
        if (dat0_rx_pos_i) begin
          if (blk_q != 16'd0 && !bad_q) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            err_d   = bad_q ? ERR_CRC_STATUS : ERR_OK;
            state_d = DONE;
          end
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        oe_d = 1'b1;
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = START;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      pos_d   = '1;
      neg_d   = '1;
      oe_d    = 1'b0;
      done_d  = 1'b0;
      crc_en  = 1'b0;
      err_d   = err_q;
    end
    ready_d = (state_d == DATA);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      bw_q    <= '0;
      word_q  <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
      bad_q   <= 1'b0;
      pos_q   <= '1;
      neg_q   <= '1;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      bw_q    <= bw_d;
      word_q  <= word_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      bad_q   <= bad_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dat_pos_o  = pos_q;
  assign dat_neg_o  = neg_q;
  assign dat_oe_o   = oe_q;
  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_code_o = err_q;

endmodule
